spi_mem_responder: RTL and testbench

Clocked-domain SPI/QSPI memory responder: the target-side counterpart of the SoC's flash/PSRAM initiator (ce, sclk, sio[3:0]). It oversamples the initiator's pins in the `clk` domain, decodes a PSRAM-style command set, and turns transfers into byte accesses on a simple synchronous memory port. It is used as an on-chip test responder and as the verification model behind ce1.

---
 rtl/spi_mem_responder.sv | 234 +++++++++++++++++++++++
 tb/tb_spi_mem_responder.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_mem_responder.sv
// SPI/QSPI PSRAM-style memory responder. Oversamples ce_n/sclk/sio in the clk domain
// and turns initiator transfers into byte reads/writes on a synchronous memory port.
//
// state  | meaning
// IDLE   | deselected, waiting for a ce_n falling edge
// CMD    | shifting the 8-bit command on sio0
// ADDR   | shifting 24 address bits (serial) or 6 nibbles (quad)
// DUMMY  | quad-read wait cycles, first read issued on the first edge
// RDATA  | driving read bytes, prefetching the next byte
// WDATA  | collecting write bytes, one mem_we per byte
// IGNORE | unknown command, idle until deselect
module spi_mem_responder #(
  parameter int ADDR_W     = 24,
  parameter int DUMMY_QUAD = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce_n,
  input  logic              sclk,
  input  logic [3:0]        sio_i,
  output logic [3:0]        sio_o,
  output logic [3:0]        sio_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata,
  output logic              mem_we,
  output logic [7:0]        mem_wdata
);

  localparam logic [7:0] CMD_READ   = 8'h03;
  localparam logic [7:0] CMD_WRITE  = 8'h02;
  localparam logic [7:0] CMD_QREAD  = 8'hEB;
  localparam logic [7:0] CMD_QWRITE = 8'h38;
  localparam logic [4:0] DUMMY_TC   = 5'(DUMMY_QUAD - 1);

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, IGNORE
  } state_t;

  state_t state_q, state_d;

  logic [1:0] ce_sync, sclk_sync;
  logic [3:0] sio_sync1, sio_s;
  logic       ce_s, ce_d, sclk_s, sclk_d;
  logic       rise, fall, ce_fall;

  logic [4:0]  cnt_q;
  logic        cnt_tc;
  logic        quad_q, read_q;
  logic [6:0]  cmd_sh;
  logic [22:0] addr_sh;
  logic [6:0]  wr_sh;
  logic [7:0]  tx_sh;
  logic [7:0]  prefetch;
  logic        rd_pend;

  logic [7:0]  cmd_word;
  logic [23:0] addr_word;
  logic [7:0]  wr_word;
  logic [7:0]  tx_byte;
  logic        cmd_known, cmd_quad, cmd_read;

  // ce regs reset to "selected" so a ce_n held low through reset never looks like a new select
  always_ff @(posedge clk) begin
    if (rst) begin
      ce_sync   <= 2'b00;
      ce_d      <= 1'b0;
      sclk_sync <= 2'b00;
      sclk_d    <= 1'b0;
      sio_sync1 <= 4'h0;
      sio_s     <= 4'h0;
    end else begin
      ce_sync   <= {ce_sync[0], ce_n};
      ce_d      <= ce_sync[1];
      sclk_sync <= {sclk_sync[0], sclk};
      sclk_d    <= sclk_sync[1];
      sio_sync1 <= sio_i;
      sio_s     <= sio_sync1;
    end
  end

  assign ce_s    = ce_sync[1];
  assign sclk_s  = sclk_sync[1];
  assign rise    = sclk_s & ~sclk_d;
  assign fall    = ~sclk_s & sclk_d;
  assign ce_fall = ~ce_s & ce_d;
  assign cnt_tc  = (cnt_q == 5'd0);

  assign cmd_word  = {cmd_sh, sio_s[0]};
  assign addr_word = quad_q ? {addr_sh[19:0], sio_s} : {addr_sh, sio_s[0]};
  assign wr_word   = quad_q ? {wr_sh[3:0], sio_s} : {wr_sh, sio_s[0]};
  // first byte of a serial read may still be in flight from memory when its first bit is due
  assign tx_byte   = rd_pend ? mem_rdata : prefetch;

  assign cmd_read  = (cmd_word == CMD_READ) || (cmd_word == CMD_QREAD);
  assign cmd_quad  = (cmd_word == CMD_QREAD) || (cmd_word == CMD_QWRITE);
  assign cmd_known = cmd_read || cmd_quad || (cmd_word == CMD_WRITE);

  always_comb begin
    state_d = state_q;
    sio_oe  = 4'h0;
    if (ce_s) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (ce_fall) state_d = CMD;
        CMD:     if (rise && cnt_tc) state_d = cmd_known ? ADDR : IGNORE;
        ADDR: begin
          if (rise && cnt_tc) begin
            if (!read_q)     state_d = WDATA;
            else if (quad_q) state_d = DUMMY;
            else             state_d = RDATA;
          end
        end
        DUMMY:   if (rise && cnt_tc) state_d = RDATA;
        RDATA:   sio_oe = quad_q ? 4'hF : 4'h2;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 5'd0;
      quad_q    <= 1'b0;
      read_q    <= 1'b0;
      cmd_sh    <= 7'h0;
      addr_sh   <= 23'h0;
      wr_sh     <= 7'h0;
      tx_sh     <= 8'h0;
      prefetch  <= 8'h0;
      rd_pend   <= 1'b0;
      sio_o     <= 4'h0;
      mem_addr  <= '0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_wdata <= 8'h0;
    end else begin
      state_q <= state_d;
      mem_re  <= 1'b0;
      mem_we  <= 1'b0;
      rd_pend <= mem_re;
      if (rd_pend) prefetch <= mem_rdata;
      if (mem_we) mem_addr <= mem_addr + ADDR_W'(1);

      if (ce_s) begin
        cnt_q <= 5'd0;
        wr_sh <= 7'h0;
        sio_o <= 4'h0;
      end else begin
        case (state_q)
          IDLE: if (ce_fall) cnt_q <= 5'd7;
          CMD: begin
            if (rise) begin
              cmd_sh <= cmd_word[6:0];
              if (cnt_tc) begin
                quad_q <= cmd_quad;
                read_q <= cmd_read;
                cnt_q  <= cmd_quad ? 5'd5 : 5'd23;
              end else begin
                cnt_q <= cnt_q - 5'd1;
              end
            end
          end
          ADDR: begin
            if (rise) begin
              addr_sh <= addr_word[22:0];
              if (cnt_tc) begin
                mem_addr <= ADDR_W'(addr_word);
                if (!read_q) begin
                  cnt_q <= quad_q ? 5'd1 : 5'd7;
                end else if (quad_q) begin
                  cnt_q <= DUMMY_TC;
                end else begin
                  cnt_q  <= 5'd0;
                  mem_re <= 1'b1;
                end
              end else begin
                cnt_q <= cnt_q - 5'd1;
              end
            end
          end
          DUMMY: begin
            if (rise) begin
              if (cnt_q == DUMMY_TC) mem_re <= 1'b1;
              cnt_q <= cnt_tc ? 5'd0 : cnt_q - 5'd1;
            end
          end
          RDATA: begin
            if (fall) begin
              if (cnt_tc) begin
                mem_addr <= mem_addr + ADDR_W'(1);
                mem_re   <= 1'b1;
                if (quad_q) begin
                  sio_o <= tx_byte[7:4];
                  tx_sh <= {tx_byte[3:0], 4'h0};
                  cnt_q <= 5'd1;
                end else begin
                  sio_o <= {2'b00, tx_byte[7], 1'b0};
                  tx_sh <= {tx_byte[6:0], 1'b0};
                  cnt_q <= 5'd7;
                end
              end else begin
                cnt_q <= cnt_q - 5'd1;
                if (quad_q) begin
                  sio_o <= tx_sh[7:4];
                  tx_sh <= {tx_sh[3:0], 4'h0};
                end else begin
                  sio_o <= {2'b00, tx_sh[7], 1'b0};
                  tx_sh <= {tx_sh[6:0], 1'b0};
                end
              end
            end
          end
          WDATA: begin
            if (rise) begin
              wr_sh <= wr_word[6:0];
              if (cnt_tc) begin
                mem_we    <= 1'b1;
                mem_wdata <= wr_word;
                cnt_q     <= quad_q ? 5'd1 : 5'd7;
              end else begin
                cnt_q <= cnt_q - 5'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_mem_responder.sv
// Directed bench for spi_mem_responder: table of read/write transfers checked against a
// behavioural memory, plus hand sequences for unknown command, abort and reset.
module tb_spi_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce_n;
  logic        sclk;
  logic [3:0]  sio_i;
  logic [3:0]  sio_o;
  logic [3:0]  sio_oe;
  logic [23:0] mem_addr;
  logic        mem_re;
  logic [7:0]  mem_rdata = 8'h00;
  logic        mem_we;
  logic [7:0]  mem_wdata;

  spi_mem_responder #(.ADDR_W(24), .DUMMY_QUAD(6)) dut (
    .clk(clk), .rst(rst), .ce_n(ce_n), .sclk(sclk), .sio_i(sio_i),
    .sio_o(sio_o), .sio_oe(sio_oe), .mem_addr(mem_addr), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .mem_we(mem_we), .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  localparam int HALF = 8;

  typedef struct packed {
    logic [23:0] a;
    logic [7:0]  d;
  } wr_t;

  typedef struct {
    logic [7:0]  cmd;
    logic [23:0] addr;
    int          nb;
    logic [7:0]  d0;
    logic [7:0]  d1;
  } vec_t;

  logic [7:0]  mem [logic [23:0]];
  wr_t         wlog[$];
  logic [23:0] rlog[$];
  bit          oe_any;

  always @(posedge clk) begin
    if (mem_re) begin
      mem_rdata <= mem.exists(mem_addr) ? mem[mem_addr] : 8'h00;
      rlog.push_back(mem_addr);
    end
    if (mem_we) begin
      mem[mem_addr] = mem_wdata;
      wlog.push_back({mem_addr, mem_wdata});
    end
    if (sio_oe != 4'h0) oe_any = 1'b1;
  end

  int n_cmp = 0;
  int n_bad = 0;
  int oe_bad;
  logic [3:0] smp_o, smp_oe;
  logic [7:0] rx [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic sclk_cycle(input logic [3:0] drv);
    sio_i = drv;
    repeat (HALF) @(negedge clk);
    smp_o  = sio_o;
    smp_oe = sio_oe;
    sclk = 1'b1;
    repeat (HALF) @(negedge clk);
    sclk = 1'b0;
  endtask

  task automatic send_bits(input logic [23:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) sclk_cycle({3'b000, v[i]});
  endtask

  task automatic send_nibs(input logic [23:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) sclk_cycle(v[i*4 +: 4]);
  endtask

  task automatic select_dev();
    ce_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic deselect_dev();
    repeat (4) @(negedge clk);
    ce_n  = 1'b1;
    sio_i = 4'h0;
    repeat (12) @(negedge clk);
  endtask

  task automatic xfer(input logic [7:0] cmd, input logic [23:0] addr, input int nb,
                      input logic [7:0] d0, input logic [7:0] d1);
    logic       quad, rd;
    logic [7:0] b, r;
    logic [3:0] eoe;
    quad = (cmd == 8'hEB) || (cmd == 8'h38);
    rd   = (cmd == 8'h03) || (cmd == 8'hEB);
    eoe  = quad ? 4'hF : 4'h2;
    oe_bad = 0;
    wlog.delete();
    rlog.delete();
    select_dev();
    send_bits({16'h0, cmd}, 8);
    if (quad) send_nibs(addr, 6);
    else      send_bits(addr, 24);
    if (cmd == 8'hEB) repeat (6) sclk_cycle(4'h0);
    for (int k = 0; k < nb; k++) begin
      b = (k == 0) ? d0 : d1;
      if (rd) begin
        r = 8'h00;
        if (quad) begin
          for (int j = 0; j < 2; j++) begin
            sclk_cycle(4'h0);
            r = {r[3:0], smp_o};
            if (smp_oe !== eoe) oe_bad++;
          end
        end else begin
          for (int j = 0; j < 8; j++) begin
            sclk_cycle(4'h0);
            r = {r[6:0], smp_o[1]};
            if (smp_oe !== eoe) oe_bad++;
          end
        end
        rx[k] = r;
      end else if (quad) begin
        send_nibs({16'h0, b}, 2);
      end else begin
        send_bits({16'h0, b}, 8);
      end
    end
    deselect_dev();
  endtask

  vec_t vecs[6];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [23:0] ea;
    logic [7:0]  ed;
    bit          is_rd;

    vecs[0] = '{cmd: 8'h02, addr: 24'h000010, nb: 2, d0: 8'hA5, d1: 8'h3C};
    vecs[1] = '{cmd: 8'h03, addr: 24'h000010, nb: 2, d0: 8'hA5, d1: 8'h3C};
    vecs[2] = '{cmd: 8'hEB, addr: 24'h123456, nb: 2, d0: 8'h5A, d1: 8'hC3};
    vecs[3] = '{cmd: 8'h38, addr: 24'hFFFFFF, nb: 2, d0: 8'h11, d1: 8'h22};
    vecs[4] = '{cmd: 8'h03, addr: 24'hFFFFFF, nb: 2, d0: 8'h11, d1: 8'h22};
    vecs[5] = '{cmd: 8'hEB, addr: 24'h000010, nb: 1, d0: 8'hA5, d1: 8'h00};
    mem[24'h123456] = 8'h5A;
    mem[24'h123457] = 8'hC3;

    rst = 1'b1; ce_n = 1'b1; sclk = 1'b0; sio_i = 4'h0;
    repeat (5) @(negedge clk);
    check("reset sio_o", {28'h0, sio_o}, 32'h0);
    check("reset sio_oe", {28'h0, sio_oe}, 32'h0);
    check("reset mem_re", {31'h0, mem_re}, 32'h0);
    check("reset mem_we", {31'h0, mem_we}, 32'h0);
    check("reset mem_addr", {8'h0, mem_addr}, 32'h0);
    check("reset mem_wdata", {24'h0, mem_wdata}, 32'h0);
    rst = 1'b0;
    repeat (6) @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      is_rd = (vecs[v].cmd == 8'h03) || (vecs[v].cmd == 8'hEB);
      xfer(vecs[v].cmd, vecs[v].addr, vecs[v].nb, vecs[v].d0, vecs[v].d1);
      if (is_rd) begin
        for (int k = 0; k < vecs[v].nb; k++) begin
          ed = (k == 0) ? vecs[v].d0 : vecs[v].d1;
          check($sformatf("vec%0d rd byte%0d", v, k), {24'h0, rx[k]}, {24'h0, ed});
        end
        check($sformatf("vec%0d sio_oe errors", v), oe_bad, 32'd0);
        check($sformatf("vec%0d first re addr", v),
              (rlog.size() > 0) ? {8'h0, rlog[0]} : 32'hFFFFFFFF, {8'h0, vecs[v].addr});
        check($sformatf("vec%0d no writes", v), wlog.size(), 32'd0);
      end else begin
        check($sformatf("vec%0d we count", v), wlog.size(), vecs[v].nb);
        for (int k = 0; k < vecs[v].nb; k++) begin
          ea = vecs[v].addr + 24'(k);
          ed = (k == 0) ? vecs[v].d0 : vecs[v].d1;
          check($sformatf("vec%0d we%0d addr", v, k),
                (wlog.size() > k) ? {8'h0, wlog[k].a} : 32'hFFFFFFFF, {8'h0, ea});
          check($sformatf("vec%0d we%0d data", v, k),
                (wlog.size() > k) ? {24'h0, wlog[k].d} : 32'hFFFFFFFF, {24'h0, ed});
        end
      end
    end

    // unknown command: bus must stay released, memory untouched
    wlog.delete(); rlog.delete(); oe_any = 1'b0;
    select_dev();
    send_bits(24'h9F, 8);
    repeat (16) sclk_cycle(4'hF);
    deselect_dev();
    check("unknown cmd oe", {31'h0, oe_any}, 32'h0);
    check("unknown cmd re", rlog.size(), 32'd0);
    check("unknown cmd we", wlog.size(), 32'd0);

    // abort after 5 bits of a write byte
    wlog.delete();
    select_dev();
    send_bits(24'h02, 8);
    send_bits(24'h000020, 24);
    send_bits(24'h16, 5);
    deselect_dev();
    check("abort no we", wlog.size(), 32'd0);
    xfer(8'h03, 24'h000010, 1, 8'hA5, 8'h00);
    check("read after abort", {24'h0, rx[0]}, 32'hA5);

    // reset in the middle of a serial read
    select_dev();
    send_bits(24'h03, 8);
    send_bits(24'h000010, 24);
    repeat (3) sclk_cycle(4'h0);
    check("mid-read oe before reset", {28'h0, sio_oe}, 32'h2);
    rst = 1'b1;
    @(negedge clk);
    check("mid-read reset sio_oe", {28'h0, sio_oe}, 32'h0);
    check("mid-read reset sio_o", {28'h0, sio_o}, 32'h0);
    check("mid-read reset mem_addr", {8'h0, mem_addr}, 32'h0);
    check("mid-read reset mem_wdata", {24'h0, mem_wdata}, 32'h0);
    check("mid-read reset strobes", {30'h0, mem_re, mem_we}, 32'h0);
    rst = 1'b0;
    oe_any = 1'b0; rlog.delete();
    repeat (8) sclk_cycle(4'h0);
    check("no restart without ce edge oe", {31'h0, oe_any}, 32'h0);
    check("no restart without ce edge re", rlog.size(), 32'd0);
    deselect_dev();
    xfer(8'h03, 24'h000010, 2, 8'hA5, 8'h3C);
    check("read after reset b0", {24'h0, rx[0]}, 32'hA5);
    check("read after reset b1", {24'h0, rx[1]}, 32'h3C);
    check("read after reset oe", oe_bad, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
